mdu_unit: RTL and testbench

- Multiply/divide unit in the execute stage, beside the ALU.
- Takes the same forwarded operand pair as the ALU and owns the architectural HI/LO registers.
- Its read result joins the ALU result at the E-stage result mux that feeds the E/M pipeline register.
- Emulates multi-cycle latency with a busy counter; the hazard unit stalls on start/busy.

---
 rtl/mdu_unit.sv | 171 +++++++++++++++++
 tb/tb_mdu_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers. A start pulse with a mult/div
// opcode computes the full 64-bit {hi,lo} result at once into pending
// registers. A busy counter then runs for MULT_CYCLES or DIV_CYCLES, and
// HI/LO take the pending value when the counter expires.
// mthi/mtlo write HI/LO directly when the unit is idle. mfhi/mflo read
// HI/LO combinationally.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   MDU_opA     forwarded rs operand
//   MDU_opB     forwarded rt operand
//   MDUop       0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//               7 mthi, 8 mtlo, others none
//   MDU_start   one-cycle pulse with MDUop 1..4
//   MDU_busy    registered, high while an operation is in flight
//   MDU_result  HI for mfhi, LO for mflo, else 0 (combinational)
//   HI_out      current HI register
//   LO_out      current LO register
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDU_opA,
  input  logic [31:0] MDU_opB,
  input  logic [3:0]  MDUop,
  input  logic        MDU_start,
  output logic        MDU_busy,
  output logic [31:0] MDU_result,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] pend_hi_reg, pend_hi_next;
  logic [31:0] pend_lo_reg, pend_lo_next;
  // Cleared for a divide by zero so completion leaves HI/LO untouched.
  logic        pend_wr_reg, pend_wr_next;
  logic [31:0] count_reg, count_next;
  logic        busy_reg, busy_next;

  // Arithmetic on the current operands.
  logic [63:0] mul_s, mul_u;
  logic        div_zero;
  logic [31:0] divisor_u, q_u, r_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;

  // The low 64 bits of the product of sign-extended operands equal the
  // signed 64-bit product.
  assign mul_s = {{32{MDU_opA[31]}}, MDU_opA} * {{32{MDU_opB[31]}}, MDU_opB};
  assign mul_u = {32'd0, MDU_opA} * {32'd0, MDU_opB};

  // A zero divisor is replaced by 1 so the dividers never see zero. The
  // result is discarded anyway.
  assign div_zero  = (MDU_opB == 32'd0);
  assign divisor_u = div_zero ? 32'd1 : MDU_opB;
  assign q_u       = MDU_opA / divisor_u;
  assign r_u       = MDU_opA % divisor_u;

  // Signed divide runs on magnitudes. The magnitude of 0x80000000 is
  // 0x80000000 as an unsigned value, so the 0x80000000 / -1 overflow case
  // naturally yields quotient 0x80000000 and remainder 0.
  assign a_neg = MDU_opA[31];
  assign b_neg = MDU_opB[31];
  assign a_mag = a_neg ? (~MDU_opA + 32'd1) : MDU_opA;
  assign b_mag = div_zero ? 32'd1 : (b_neg ? (~MDU_opB + 32'd1) : MDU_opB);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    count_next   = count_reg;
    busy_next    = busy_reg;

    if (busy_reg) begin
      // Starts and mthi/mtlo are ignored while busy.
      if (count_reg == 32'd1) begin
        if (pend_wr_reg) begin
          hi_next = pend_hi_reg;
          lo_next = pend_lo_reg;
        end
        count_next = 32'd0;
        busy_next  = 1'b0;
      end else begin
        count_next = count_reg - 32'd1;
      end
    end else if (MDU_start && (MDUop >= OP_MULT) && (MDUop <= OP_DIVU)) begin
      busy_next = 1'b1;
      case (MDUop)
        OP_MULT: begin
          {pend_hi_next, pend_lo_next} = mul_s;
          pend_wr_next = 1'b1;
          count_next   = 32'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {pend_hi_next, pend_lo_next} = mul_u;
          pend_wr_next = 1'b1;
          count_next   = 32'(MULT_CYCLES);
        end
        OP_DIV: begin
          pend_hi_next = r_s;
          pend_lo_next = q_s;
          pend_wr_next = !div_zero;
          count_next   = 32'(DIV_CYCLES);
        end
        default: begin
          pend_hi_next = r_u;
          pend_lo_next = q_u;
          pend_wr_next = !div_zero;
          count_next   = 32'(DIV_CYCLES);
        end
      endcase
    end else if (MDUop == OP_MTHI) begin
      hi_next = MDU_opA;
    end else if (MDUop == OP_MTLO) begin
      lo_next = MDU_opA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
      count_reg   <= 32'd0;
      busy_reg    <= 1'b0;
    end else begin
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
      count_reg   <= count_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    MDU_result = 32'd0;
    if (MDUop == OP_MFHI)      MDU_result = hi_reg;
    else if (MDUop == OP_MFLO) MDU_result = lo_reg;
  end

  assign MDU_busy = busy_reg;
  assign HI_out   = hi_reg;
  assign LO_out   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed plus randomized checks of mdu_unit against a
// behavioural HI/LO model built from plain integer arithmetic.
module tb_mdu_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] MDU_opA, MDU_opB;
  logic [3:0]  MDUop;
  logic        MDU_start;
  logic        MDU_busy;
  logic [31:0] MDU_result, HI_out, LO_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDU_opA(MDU_opA), .MDU_opB(MDU_opB),
    .MDUop(MDUop), .MDU_start(MDU_start), .MDU_busy(MDU_busy),
    .MDU_result(MDU_result), .HI_out(HI_out), .LO_out(LO_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what HI/LO become once an accepted op completes.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd1: begin
        ps = longint'(sa) * longint'(sb);
        model_hi = ps[63:32]; model_lo = ps[31:0];
      end
      4'd2: begin
        pu = longint'(unsigned'(a)) * longint'(unsigned'(b));
        model_hi = pu[63:32]; model_lo = pu[31:0];
      end
      4'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          model_lo = 32'h8000_0000; model_hi = 32'd0;
        end else begin
          model_lo = sa / sb; model_hi = sa % sb;
        end
      end
      4'd4: if (b != 0) begin
        model_lo = a / b; model_hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Runs one accepted op to completion; optionally pokes a start and an
  // mthi into the busy window, both of which must be ignored.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit inject);
    int n, expn;
    logic [31:0] old_hi;
    expn = (op <= 4'd2) ? MULT_N : DIV_N;
    old_hi = model_hi;
    MDUop = op; MDU_opA = a; MDU_opB = b; MDU_start = 1'b1;
    @(negedge clk);
    MDU_start = 1'b0; MDUop = 4'd0;
    n = 0;
    while (MDU_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 1) check({tag, "_hi_during_busy"}, HI_out, old_hi);
      if (inject && n == 3) begin
        MDU_start = 1'b1; MDUop = 4'd1; MDU_opA = $urandom; MDU_opB = $urandom;
      end else if (inject && n == 5) begin
        MDU_start = 1'b0; MDUop = 4'd7; MDU_opA = 32'hDEAD_BEEF;
      end else if (inject) begin
        MDU_start = 1'b0; MDUop = 4'd0;
      end
      @(negedge clk);
    end
    MDU_start = 1'b0; MDUop = 4'd0;
    model_apply(op, a, b);
    check({tag, "_busy_cycles"}, 32'(n), 32'(expn));
    check({tag, "_hi"}, HI_out, model_hi);
    check({tag, "_lo"}, LO_out, model_lo);
    $display("op=%0d a=%h b=%h busy=%0d HI=%h LO=%h", op, a, b, n, HI_out, LO_out);
  endtask

  task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
    MDUop = op; MDU_opA = a;
    @(negedge clk);
    MDUop = 4'd0;
    if (op == 4'd7) model_hi = a; else model_lo = a;
    check({tag, "_hi"}, HI_out, model_hi);
    check({tag, "_lo"}, LO_out, model_lo);
    $display("mt op=%0d a=%h HI=%h LO=%h", op, a, HI_out, LO_out);
  endtask

  task automatic do_reads(input string tag);
    MDUop = 4'd5; #1;
    check({tag, "_mfhi"}, MDU_result, model_hi);
    MDUop = 4'd6; #1;
    check({tag, "_mflo"}, MDU_result, model_lo);
    MDUop = 4'd0; #1;
    check({tag, "_mfnone"}, MDU_result, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int n;
    reset = 1'b1; MDU_start = 1'b0; MDUop = 4'd0; MDU_opA = 32'd0; MDU_opB = 32'd0;
    @(negedge clk); @(negedge clk);
    check("reset_busy", {31'd0, MDU_busy}, 32'd0);
    check("reset_hi", HI_out, 32'd0);
    check("reset_lo", LO_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_neg_hi_const", HI_out, 32'hFFFF_FFFF);
    check("mult_neg_lo_const", LO_out, 32'hFFFF_FFFA);
    do_reads("mult_neg");
    do_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", HI_out, 32'hFFFF_FFFE);
    check("multu_max_lo_const", LO_out, 32'h0000_0001);
    do_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", LO_out, 32'hFFFF_FFFD);
    check("div_neg_hi_const", HI_out, 32'hFFFF_FFFF);
    do_op("divu", 4'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_const", LO_out, 32'd3);
    do_mt("mthi", 4'd7, 32'h1234_5678);
    do_op("divu_zero", 4'd4, 32'd99, 32'd0, 1'b1);
    check("divu_zero_hi_const", HI_out, 32'h1234_5678);

    // Reset in the middle of a mult aborts it.
    MDUop = 4'd1; MDU_opA = 32'd3; MDU_opB = 32'd4; MDU_start = 1'b1;
    @(negedge clk);
    MDU_start = 1'b0; MDUop = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    check("abort_busy", {31'd0, MDU_busy}, 32'd0);
    check("abort_hi", HI_out, 32'd0);
    check("abort_lo", LO_out, 32'd0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (MDU_busy !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) n++;
    end
    check("abort_stays_idle", 32'(n), 32'd0);
    do_op("mult_after_abort", 4'd1, 32'd2, 32'd2, 1'b0);
    check("mult_after_abort_lo_const", LO_out, 32'd4);

    do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", LO_out, 32'h8000_0000);
    check("div_ovf_hi_const", HI_out, 32'd0);
    do_mt("mtlo_at_drop", 4'd8, 32'h0000_00AA);
    do_reads("mtlo_at_drop");

    // Back-to-back start in the first idle cycle.
    do_op("b2b_a", 4'd2, 32'd10, 32'd20, 1'b0);
    do_op("b2b_b", 4'd3, 32'hFFFF_FF00, 32'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (rop == 4'd3 || rop == 4'd4) rb = rb >> $urandom_range(0, 28);
      if (rop <= 4'd4) do_op("rand", rop, ra, rb, ($urandom_range(0, 3) == 0));
      else do_mt("rand_mt", (rop == 4'd5) ? 4'd7 : 4'd8, ra);
      do_reads("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
